// File: rtl/data_cache.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// data_cache
//
// Direct-mapped, write-through, no-write-allocate data cache sitting between
// the memory stage and data_mem. Lines are one data word wide. Aligned loads
// hit in the request cycle. Aligned load misses refill the line with a word
// read and stall the pipeline for two cycles. Stores always go straight
// through to data_mem. Misaligned loads bypass the cache.
//
// Ports
//   clk        sole clock, all state on the rising edge
//   rst        synchronous, active-high reset
//   AddrMode   request mode: 0-4 loads (LB,LH,LW,LBU,LHU), 5-7 stores
//              (SB,SH,SW), 8-15 no access
//   A          request byte address
//   WD         store data, low bytes used according to mode
//   RD         load result, sign/zero extended according to mode
//   stall      request not complete; pipeline holds AddrMode/A/WD
//   mem_mode   mode driven to data_mem (4'b1000 = idle)
//   mem_addr   address driven to data_mem
//   mem_wd     write data driven to data_mem
//   mem_rd     combinational read data returned by data_mem
//   hit_count  (DCACHE_STATS_EN only) wrapping count of cached load hits
//   miss_count (DCACHE_STATS_EN only) wrapping count of refills started
//
// Optional feature
//   Define DCACHE_STATS_EN to add the hit/miss counters and their ports.
// ---------------------------------------------------------------------------
module data_cache #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int ADDR_REAL_WIDTH = 20,
    parameter int INDEX_BITS      = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            AddrMode,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] WD,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  stall,
    output logic [3:0]            mem_mode,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_REAL_WIDTH - INDEX_BITS - 2;
    localparam int LANES = DATA_WIDTH / 8;

    localparam logic [3:0] MODE_LB   = 4'b0000;
    localparam logic [3:0] MODE_LH   = 4'b0001;
    localparam logic [3:0] MODE_LW   = 4'b0010;
    localparam logic [3:0] MODE_LBU  = 4'b0011;
    localparam logic [3:0] MODE_LHU  = 4'b0100;
    localparam logic [3:0] MODE_SB   = 4'b0101;
    localparam logic [3:0] MODE_SH   = 4'b0110;
    localparam logic [3:0] MODE_SW   = 4'b0111;
    localparam logic [3:0] MODE_NONE = 4'b1000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    state_t state_reg;

    // Line storage. Read asynchronously so that a hit completes in the same
    // cycle the request is presented.
    logic [DATA_WIDTH-1:0] line_data_reg [LINES];
    logic [TAG_W-1:0]      line_tag_reg  [LINES];
    logic [LINES-1:0]      valid_reg;

    // Request decode
    logic                  is_load;
    logic                  is_store;
    logic                  aligned;
    logic [INDEX_BITS-1:0] index;
    logic [INDEX_BITS-1:0] idx_next;
    logic [TAG_W-1:0]      tag;
    logic                  fill_now;
    logic                  line_hit;
    logic [DATA_WIDTH-1:0] line_word;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [LANES-1:0]      byte_en;
    logic [DATA_WIDTH-1:0] merged_word;
    logic                  line_we;
    logic [DATA_WIDTH-1:0] line_wdata;

    assign is_load  = (AddrMode <= MODE_LHU);
    assign is_store = (AddrMode >= MODE_SB) && (AddrMode <= MODE_SW);

    always_comb begin
        case (AddrMode)
            MODE_LH, MODE_LHU, MODE_SH: aligned = ~A[0];
            MODE_LW, MODE_SW:           aligned = (A[1:0] == 2'b00);
            default:                    aligned = 1'b1;
        endcase
    end

    assign index    = A[INDEX_BITS+1:2];
    // A misaligned word store spills into the following word, whose index
    // is simply the next one (wrapping at the top of the array).
    assign idx_next = index + {{(INDEX_BITS-1){1'b0}}, 1'b1};
    assign tag      = A[ADDR_REAL_WIDTH-1:INDEX_BITS+2];
    assign fill_now = (state_reg == ST_FILL);

    assign line_word = line_data_reg[index];
    assign line_hit  = valid_reg[index] && (line_tag_reg[index] == tag);

    // Load extraction from the cached word, extended as data_mem would.
    assign sel_byte = line_word[{A[1:0], 3'b000} +: 8];
    assign sel_half = line_word[{A[1], 4'b0000} +: 16];

    always_comb begin
        case (AddrMode)
            MODE_LB:  load_ext = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
            MODE_LH:  load_ext = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
            MODE_LW:  load_ext = line_word;
            MODE_LBU: load_ext = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
            MODE_LHU: load_ext = {{(DATA_WIDTH-16){1'b0}}, sel_half};
            default:  load_ext = '0;
        endcase
    end

    // Per-lane byte merge for store hits. Stores take their data from the
    // low bytes of WD, so a byte/half store replicates into the lane it
    // targets.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] lane_wd;

            assign byte_en[gi] = (AddrMode == MODE_SW)
                              || ((AddrMode == MODE_SH) && (A[1] == 1'((gi / 2) % 2)))
                              || ((AddrMode == MODE_SB) && (A[1:0] == 2'(gi % 4)));

            assign lane_wd = (AddrMode == MODE_SB) ? WD[7:0] :
                             (AddrMode == MODE_SH) ? WD[8*(gi%2) +: 8] :
                                                     WD[8*gi +: 8];

            assign merged_word[8*gi +: 8] = byte_en[gi] ? lane_wd
                                                        : line_word[8*gi +: 8];
        end
    endgenerate

    // Line write: refill in FILL, or merge on an aligned store hit in IDLE.
    // Reset suppresses the write so an interrupted refill leaves no trace.
    assign line_we    = !rst && (fill_now || (is_store && aligned && line_hit));
    assign line_wdata = fill_now ? mem_rd : merged_word;

    always_ff @(posedge clk) begin
        if (line_we) begin
            line_data_reg[index] <= line_wdata;
            line_tag_reg[index]  <= tag;
        end
    end

    // Combinational request outputs. Hits must return data in the same
    // cycle, so RD/stall/mem_* are decoded directly from the request.
    always_comb begin
        stall    = 1'b0;
        mem_mode = MODE_NONE;
        mem_addr = A;
        mem_wd   = WD;
        RD       = '0;
        if (!rst) begin
            if (fill_now) begin
                stall    = 1'b1;
                mem_mode = MODE_LW;
                mem_addr = {A[ADDR_WIDTH-1:2], 2'b00};
            end else if (is_store) begin
                mem_mode = AddrMode;
            end else if (is_load && !aligned) begin
                // Uncached: data_mem deals with the misaligned access.
                mem_mode = AddrMode;
                RD       = mem_rd;
            end else if (is_load) begin
                if (line_hit) begin
                    RD = load_ext;
                end else begin
                    stall = 1'b1;
                end
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_reg;
    logic [31:0] miss_cnt_reg;
    // The completing cycle right after a refill is a hit by construction;
    // it is excluded from the hit count because it was already a miss.
    logic        fill_prev_reg;

    assign hit_count  = hit_cnt_reg;
    assign miss_count = miss_cnt_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            valid_reg <= '0;
`ifdef DCACHE_STATS_EN
            hit_cnt_reg   <= '0;
            miss_cnt_reg  <= '0;
            fill_prev_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (is_load && aligned && !line_hit) begin
                        state_reg <= ST_FILL;
                    end
                    if (is_store && !aligned) begin
                        // The store may straddle two words; drop both so
                        // neither can return stale bytes.
                        valid_reg[index]    <= 1'b0;
                        valid_reg[idx_next] <= 1'b0;
                    end
                end
                ST_FILL: begin
                    valid_reg[index] <= 1'b1;
                    state_reg        <= ST_IDLE;
                end
            endcase
`ifdef DCACHE_STATS_EN
            fill_prev_reg <= fill_now;
            if (!fill_now && is_load && aligned && line_hit && !fill_prev_reg) begin
                hit_cnt_reg <= hit_cnt_reg + 32'd1;
            end
            if (!fill_now && is_load && aligned && !line_hit) begin
                miss_cnt_reg <= miss_cnt_reg + 32'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_data_cache.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_data_cache
//
// Drives data_cache against a byte-addressed behavioural data_mem. A
// reference model (its own byte memory plus a valid/tag table) predicts RD,
// stall length and the data_mem request for every access; the expected
// response is queued by the driver and popped by a monitor when the DUT
// completes the access (stall low).
// ---------------------------------------------------------------------------
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  AddrMode;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        stall;
    logic [3:0]  mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    always #5 clk = ~clk;

    data_cache dut (
        .clk      (clk),
        .rst      (rst),
        .AddrMode (AddrMode),
        .A        (A),
        .WD       (WD),
        .RD       (RD),
        .stall    (stall),
        .mem_mode (mem_mode),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // ------------------------------------------------------------------
    // Memories: dm_mem is the simulated data_mem behind the DUT, ref_mem is
    // the reference model's view updated directly from the stimulus.
    // ------------------------------------------------------------------
    bit [7:0] ref_mem [int];
    bit [7:0] dm_mem  [int];
    int       mem_version = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    function automatic bit [7:0] rbyte(input bit use_ref, input logic [31:0] a);
        int key;
        key = int'(a[19:0]);
        if (use_ref) return ref_mem.exists(key) ? ref_mem[key] : 8'h00;
        return dm_mem.exists(key) ? dm_mem[key] : 8'h00;
    endfunction

    function automatic logic [31:0] mem_load(input bit use_ref, input logic [3:0] mode,
                                             input logic [31:0] a);
        bit [7:0] b0, b1, b2, b3;
        b0 = rbyte(use_ref, a);
        b1 = rbyte(use_ref, a + 32'd1);
        b2 = rbyte(use_ref, a + 32'd2);
        b3 = rbyte(use_ref, a + 32'd3);
        case (mode)
            4'd0:    return {{24{b0[7]}}, b0};
            4'd1:    return {{16{b1[7]}}, b1, b0};
            4'd2:    return {b3, b2, b1, b0};
            4'd3:    return {24'h0, b0};
            4'd4:    return {16'h0, b1, b0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic mem_store(input bit use_ref, input logic [3:0] mode,
                             input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = (mode == 4'd5) ? 1 : (mode == 4'd6) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            logic [31:0] ai;
            int key;
            ai  = a + 32'(i);
            key = int'(ai[19:0]);
            if (use_ref) ref_mem[key] = wd[8*i +: 8];
            else         dm_mem[key]  = wd[8*i +: 8];
        end
    endtask

    // Behavioural data_mem: combinational read, writes on the clock edge.
    always @(mem_mode or mem_addr or mem_version) begin
        mem_rd = mem_load(1'b0, mem_mode, mem_addr);
    end

    always @(posedge clk) begin
        if (mem_mode >= 4'd5 && mem_mode <= 4'd7) begin
            mem_store(1'b0, mem_mode, mem_addr, mem_wd);
            mem_version++;
        end
    end

    // ------------------------------------------------------------------
    // Reference cache model: which word address each line holds.
    // ------------------------------------------------------------------
    bit m_valid [64];
    int m_tag   [64];
    int m_hits;
    int m_misses;

    task automatic model_reset;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    function automatic bit is_aligned(input logic [3:0] mode, input logic [31:0] a);
        case (mode)
            4'd1, 4'd4, 4'd6: return a[0] == 1'b0;
            4'd2, 4'd7:       return a[1:0] == 2'b00;
            default:          return 1'b1;
        endcase
    endfunction

    typedef struct {
        string       nm;
        logic [31:0] a;
        int          stalls;
        logic [3:0]  mode;
        bit          chk_rd;
        logic [31:0] rd;
        bit          chk_addr;
        bit          chk_wd;
        logic [31:0] wd;
    } exp_t;

    exp_t exp_q [$];
    bit   mon_en = 1'b1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, got, want);
        end
    endtask

    task automatic finish_up;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    // ------------------------------------------------------------------
    // Monitor: counts stall cycles of the current access and compares the
    // completed access against the head of the expectation queue.
    // ------------------------------------------------------------------
    int   stall_cnt = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (!mon_en) begin
            stall_cnt = 0;
        end else if (exp_q.size() != 0) begin
            if (stall) begin
                stall_cnt++;
                if (stall_cnt == 2) begin
                    check({exp_q[0].nm, "_fill_mode"}, 32'(mem_mode), 32'h2);
                    check({exp_q[0].nm, "_fill_addr"}, mem_addr, exp_q[0].a & ~32'h3);
                end
            end else begin
                mon_e = exp_q.pop_front();
                n_txn++;
                check({mon_e.nm, "_stalls"}, 32'(stall_cnt), 32'(mon_e.stalls));
                check({mon_e.nm, "_mem_mode"}, 32'(mem_mode), 32'(mon_e.mode));
                if (mon_e.chk_rd)   check({mon_e.nm, "_rd"}, RD, mon_e.rd);
                if (mon_e.chk_addr) check({mon_e.nm, "_mem_addr"}, mem_addr, mon_e.a);
                if (mon_e.chk_wd)   check({mon_e.nm, "_mem_wd"}, mem_wd, mon_e.wd);
                $display("txn %0d %s mode=%h A=%h RD=%h stalls=%0d",
                         n_txn, mon_e.nm, AddrMode, A, RD, stall_cnt);
                stall_cnt = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic do_op(input logic [3:0] mode, input logic [31:0] a, input logic [31:0] wd,
                         input string nm, input bit use_rd, input logic [31:0] rd_c,
                         input int stall_c);
        exp_t e;
        int   idx;
        int   tg;
        bit   ld;
        bit   st;
        bit   al;
        int   k;
        ld  = (mode <= 4'd4);
        st  = (mode >= 4'd5) && (mode <= 4'd7);
        al  = is_aligned(mode, a);
        idx = int'(a[7:2]);
        tg  = int'(a[19:8]);
        e.nm       = nm;
        e.a        = a;
        e.stalls   = 0;
        e.mode     = 4'b1000;
        e.chk_rd   = !st;
        e.rd       = 32'h0;
        e.chk_addr = 1'b0;
        e.chk_wd   = st;
        e.wd       = wd;
        if (ld) begin
            e.rd = mem_load(1'b1, mode, a);
            if (!al) begin
                e.mode     = mode;
                e.chk_addr = 1'b1;
            end else if (m_valid[idx] && m_tag[idx] == tg) begin
                m_hits++;
            end else begin
                e.stalls     = 2;
                m_misses++;
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
            end
        end else if (st) begin
            e.mode     = mode;
            e.chk_addr = 1'b1;
            mem_store(1'b1, mode, a, wd);
            if (!al) begin
                m_valid[idx]            = 1'b0;
                m_valid[(idx + 1) % 64] = 1'b0;
            end
        end
        if (use_rd)       e.rd     = rd_c;
        if (stall_c >= 0) e.stalls = stall_c;

        @(posedge clk);
        #1;
        exp_q.push_back(e);
        AddrMode = mode;
        A        = a;
        WD       = wd;
        k = 0;
        @(negedge clk);
        while (stall && k < 8) begin
            @(negedge clk);
            k++;
        end
        if (stall) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout_%s: stall still 1 after 8 cycles, want 0", nm);
            finish_up();
        end
    endtask

    // One idle cycle, then compare the statistics counters (if present).
    task automatic check_stats;
        @(posedge clk);
        #1;
        AddrMode = 4'b1000;
`ifdef DCACHE_STATS_EN
        check("hit_count", hit_count, 32'(m_hits));
        check("miss_count", miss_count, 32'(m_misses));
`endif
    endtask

    // Reset with a load request held on the inputs: outputs must stay quiet.
    task automatic apply_reset;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        AddrMode = 4'd2;
        A        = 32'h0001_0000;
        WD       = 32'h0;
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_mem_mode", 32'(mem_mode), 32'h8);
        check("rst_rd", RD, 32'h0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        AddrMode = 4'b1000;
        model_reset();
        check_stats();
    endtask

    localparam logic [11:0] TAGS [4] = '{12'h100, 12'h101, 12'h200, 12'hFFF};

    initial begin
        rst      = 1'b1;
        AddrMode = 4'b1000;
        A        = 32'h0;
        WD       = 32'h0;
        model_reset();
        mem_store(1'b1, 4'd7, 32'h0001_0000, 32'h8899_AABB);
        mem_store(1'b0, 4'd7, 32'h0001_0000, 32'h8899_AABB);
        mem_version++;
        repeat (2) @(posedge clk);

        // Cold LW then repeat
        apply_reset();
        do_op(4'd2, 32'h0001_0000, 32'h0, "cold_lw",   1'b1, 32'h8899_AABB, 2);
        do_op(4'd2, 32'h0001_0000, 32'h0, "repeat_lw", 1'b1, 32'h8899_AABB, 0);
        check_stats();

        // Sub-word loads on the filled line
        do_op(4'd0, 32'h0001_0001, 32'h0, "lb",  1'b1, 32'hFFFF_FFAA, 0);
        do_op(4'd3, 32'h0001_0003, 32'h0, "lbu", 1'b1, 32'h0000_0088, 0);
        do_op(4'd1, 32'h0001_0002, 32'h0, "lh",  1'b1, 32'hFFFF_8899, 0);

        // Store hit, then store miss (no allocate)
        do_op(4'd5, 32'h0001_0000, 32'h0000_0055, "sb_hit",       1'b0, 32'h0, 0);
        do_op(4'd2, 32'h0001_0000, 32'h0, "lw_after_sb",          1'b1, 32'h8899_AA55, 0);
        do_op(4'd7, 32'h0002_0000, 32'hCAFE_F00D, "sw_miss",      1'b0, 32'h0, 0);
        do_op(4'd2, 32'h0002_0000, 32'h0, "lw_after_sw_miss",     1'b1, 32'hCAFE_F00D, 2);

        // Conflict eviction on index 0
        do_op(4'd2, 32'h0001_0000, 32'h0, "conflict_a",       1'b1, 32'h8899_AA55, 2);
        do_op(4'd2, 32'h0001_0100, 32'h0, "conflict_b",       1'b1, 32'h0, 2);
        do_op(4'd2, 32'h0001_0000, 32'h0, "conflict_a_again", 1'b1, 32'h8899_AA55, 2);

        // Misaligned SW invalidates both touched lines
        do_op(4'd2, 32'h0001_0004, 32'h0, "lw_10004",            1'b0, 32'h0, 2);
        do_op(4'd7, 32'h0001_0002, 32'h1122_3344, "sw_misaligned", 1'b0, 32'h0, 0);
        do_op(4'd2, 32'h0001_0000, 32'h0, "lw_after_mis_sw",     1'b1, 32'h3344_AA55, 2);
        do_op(4'd2, 32'h0001_0004, 32'h0, "lw4_after_mis_sw",    1'b1, 32'h0000_1122, 2);
        do_op(4'd2, 32'h0001_0001, 32'h0, "lw_misaligned",       1'b1, 32'h2233_44AA, 0);
        check_stats();

        // Reset in the FILL cycle abandons the refill
        apply_reset();
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        AddrMode = 4'd2;
        A        = 32'h0001_0000;
        @(negedge clk);
        check("midfill_miss_stall", 32'(stall), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midfill_rst_stall", 32'(stall), 32'h0);
        check("midfill_rst_mem_mode", 32'(mem_mode), 32'h8);
        check("midfill_rst_rd", RD, 32'h0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        AddrMode = 4'b1000;
        model_reset();
        mon_en = 1'b1;
        do_op(4'd2, 32'h0001_0000, 32'h0, "lw_after_midfill_rst", 1'b1, 32'h3344_AA55, 2);
        check_stats();

        // Randomised traffic over a few conflicting tags and eight indices
        for (int n = 0; n < 300; n++) begin
            logic [3:0]  md;
            logic [31:0] ad;
            int          r;
            r  = int'($urandom_range(0, 19));
            md = (r < 16) ? 4'(r % 8) : 4'(8 + $urandom_range(0, 7));
            ad = {12'h0, TAGS[$urandom_range(0, 3)], 6'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3))};
            do_op(md, ad, $urandom, "rand", 1'b0, 32'h0, -1);
            if (n % 50 == 49) check_stats();
        end
        check_stats();

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end
        finish_up();
    end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache between the memory stage and `data_mem`. It accepts the same 4-bit access mode and byte address the memory stage would drive to `data_mem`, serves aligned loads from one-word lines, and refills misses with a word read. It raises `stall` to freeze the pipeline while a refill is in flight. All stores go straight through to `data_mem` in the cycle they are accepted.

## Interface
- `DATA_WIDTH`, 32, data word width
- `ADDR_WIDTH`, 32, byte address width
- `ADDR_REAL_WIDTH`, 20, implemented address bits; tag = `A[ADDR_REAL_WIDTH-1:INDEX_BITS+2]`
- `INDEX_BITS`, 6, log2 of line count (64 one-word lines)

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `AddrMode`  in  4  request mode:
  - loads: 0000 LB, 0001 LH, 0010 LW, 0011 LBU, 0100 LHU
  - stores: 0101 SB, 0110 SH, 0111 SW
  - 1000–1111: no access
- `A`  in  32  request byte address
- `WD`  in  32  store data, low bytes used per mode
- `RD`  out  32  load result, extended per mode
- `stall`  out  1  request not complete; pipeline holds `AddrMode`/`A`/`WD` stable
- `mem_mode`  out  4  mode to `data_mem`
- `mem_addr`  out  32  address to `data_mem`
- `mem_wd`  out  32  write data to `data_mem`
- `mem_rd`  in  32  combinational read data from `data_mem`
- `hit_count`, `miss_count`  out  32 each  only with `DCACHE_STATS_EN`

## Operation
- **Storage:** per line `valid`, tag, 32-bit data.
- **Index:** `A[INDEX_BITS+1:2]`.
- **Aligned access:** any byte; LH/LHU/SH with `A[0]==0`; LW/SW with `A[1:0]==0`.
- **States:** IDLE, FILL.
- **IDLE, aligned load, hit (valid and tag match):**
  - `RD` = selected byte/half/word from the line, sign- or zero-extended as in `data_mem`.
  - `stall=0`.
  - `mem_mode=4'b1000`.
- **IDLE, aligned load, miss:**
  - `stall=1`; next state FILL.
- **FILL:**
  - Drive `mem_mode=0010`, `mem_addr={A[31:2],2'b00}`; `stall=1`.
  - At the clock edge: line ← `mem_rd`, tag written, `valid=1`; next state IDLE.
- **Misaligned load:** uncached.
  - `mem_mode=AddrMode`, `mem_addr=A`, `RD=mem_rd`, `stall=0`.
  - Cache state unchanged.
- **Store (any alignment):** `mem_mode/mem_addr/mem_wd = AddrMode/A/WD` in IDLE, `stall=0`.
  - Aligned hit: byte-merge `WD` into the line at the same edge.
  - Aligned miss: no allocate.
  - Misaligned: clear `valid` at both indices of `A` and `A+4`.
- **No-access mode:** `stall=0`, `mem_mode=4'b1000`, `RD=0`.
- **Outside FILL:** `mem_addr=A` and `mem_wd=WD` whenever a store or misaligned load is not being driven.

## Timing
- **Load hit:** 0 stall cycles; `RD` combinational from `A`.
- **Load miss:** exactly 2 stall cycles.
  - Cycle n: miss detected.
  - Cycle n+1: FILL.
  - Cycle n+2: hit, `RD` valid, `stall=0`.
- **Store:** 0 stall cycles; `data_mem` and cache line update at the same edge.
- **Reset (`rst` high at an edge):**
  - All `valid` cleared, state → IDLE, counters → 0.
  - While `rst` is high: `stall=0`, `mem_mode=4'b1000`, `RD=0`.
- **Reset during FILL:** line not written, FILL abandoned.
- **`A` changes while `stall=1`:** protocol violation; behaviour undefined.
- **Back-to-back accesses:** store then load to the same word returns the new data with 0 stall if the line was valid.

## Configuration
- **`DCACHE_STATS_EN` defined:** `hit_count` and `miss_count` ports and counters exist; both 32-bit and wrapping.
  - `miss_count` +1 on each IDLE→FILL transition.
  - `hit_count` +1 on each aligned load completing in IDLE when the previous cycle was not FILL.
- **`DCACHE_STATS_EN` undefined:** ports and counters are absent; behaviour otherwise identical.

## Test plan
Setup for all scenarios: preload `data_mem` word 0x00010000 = 0x8899AABB.
- **Cold LW then repeat:** reset, LW 0x10000.
  - `stall=1` for 2 cycles, then `RD=0x8899AABB`.
  - Repeat LW: `stall=0` same cycle.
  - Stats: miss=1, hit=1.
- **Sub-word loads after fill:**
  - LB 0x10001 → `0xFFFFFFAA`.
  - LBU 0x10003 → `0x00000088`.
  - LH 0x10002 → `0xFFFF8899`.
  - All `stall=0`.
- **Store hit then miss:** after fill, SB 0x10000 WD=0x55.
  - `mem_mode=0101` that cycle; then LW 0x10000 → `0x8899AA55`, 0 stall.
  - SW to 0x20000 (miss), then LW 0x20000: 2-cycle stall, returns stored word.
- **Conflict eviction:** LW 0x10000 then LW 0x10100 (same index, INDEX_BITS=6).
  - Each misses.
  - LW 0x10000 misses again.
- **Misaligned SW:** SW 0x10002 WD=0x11223344.
  - No stall; `mem_mode=0111`, `mem_addr=0x10002`.
  - Lines at 0x10000 and 0x10004 invalidated; next LW 0x10000 misses → `0x3344AA55`.
- **Reset mid-FILL:** assert `rst` in the FILL cycle.
  - Next cycle `stall=0`, `mem_mode=1000`.
  - LW 0x10000 misses again.
